sig_dump_device: RTL and testbench

Memory-mapped signature buffer for the compliance simulation top, attached as a bus device next to the test utility. Test software pushes 32-bit signature words through a device port. The block queues them in a FIFO and streams them to a simulation-side consumer over a valid/ready port. A halt request drains the FIFO before raising a halt flag with an exit code.

---
 rtl/sig_dump_device.sv | 169 ++++++++++++++++
 tb/tb_sig_dump_device.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_dump_device.sv
// Memory-mapped signature buffer: device-port writes are queued in a FIFO and
// streamed out over valid/ready; a HALT write drains the FIFO, then raises halt_o.
module sig_dump_device #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [3:0]  dev_be_i,
  input  logic [31:0] dev_wdata_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        sig_valid_o,
  input  logic        sig_ready_i,
  output logic [31:0] sig_data_o,
  output logic        halt_o,
  output logic [7:0]  exit_code_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [7:0] OFF_PUSH   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h01;
  localparam logic [7:0] OFF_HALT   = 8'h02;
  localparam logic [7:0] OFF_CLR    = 8'h03;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [7:0]      exit_code_q;

  logic [7:0]      word_off;
  logic            empty, full, pop;
  logic            push, set_ovf, clr_ovf, halt_wr;
  logic            resp_err;
  logic [31:0]     resp_data;
  logic [31:0]     status_word;
  logic            unused_addr_bits;

  assign word_off         = dev_addr_i[9:2];
  assign unused_addr_bits = ^{dev_addr_i[31:10], dev_addr_i[1:0]};

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty && sig_ready_i;

  always_comb begin
    status_word           = '0;
    status_word[CW-1:0]   = count;
    status_word[16]       = empty;
    status_word[17]       = full;
    status_word[18]       = ovf;
    status_word[19]       = (state_q != ST_RUN);
  end

  // Request decode and next-state logic.
  // NOTE: every signal gets a default before the branches so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    push      = 1'b0;
    set_ovf   = 1'b0;
    clr_ovf   = 1'b0;
    halt_wr   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    state_d   = state_q;

    if (dev_req_i) begin
      if (dev_we_i) begin
        if (dev_be_i != 4'hF) begin
          resp_err = 1'b1;
        end else begin
          unique case (word_off)
            OFF_PUSH: begin
              if (state_q == ST_RUN && (!full || pop)) begin
                push = 1'b1;
              end else begin
                resp_err = 1'b1;
                // Only a full FIFO in RUN counts as overflow; late pushes do not.
                set_ovf  = (state_q == ST_RUN);
              end
            end
            OFF_STATUS: resp_err = 1'b1;
            OFF_HALT: begin
              if (state_q == ST_RUN) halt_wr  = 1'b1;
              else                   resp_err = 1'b1;
            end
            OFF_CLR:  clr_ovf  = 1'b1;
            default:  resp_err = 1'b1;
          endcase
        end
      end else begin
        unique case (word_off)
          OFF_PUSH:   resp_data = '0;
          OFF_STATUS: resp_data = status_word;
          OFF_HALT:   resp_data = {24'h0, exit_code_q};
          OFF_CLR:    resp_data = '0;
          default:    resp_err  = 1'b1;
        endcase
      end
    end

    unique case (state_q)
      ST_RUN:   if (halt_wr) state_d = ST_DRAIN;
      ST_DRAIN: if (empty)   state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      exit_code_q  <= '0;
      dev_rvalid_o <= 1'b0;
      dev_rdata_o  <= '0;
      dev_err_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dev_rvalid_o <= dev_req_i;
      dev_rdata_o  <= resp_data;
      dev_err_o    <= resp_err;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (set_ovf)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      if (halt_wr) exit_code_q <= dev_wdata_i[7:0];
    end
  end

  // NOTE: the storage array has no reset; count and pointers define which
  // entries are live, so clearing the data itself would be wasted logic.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dev_wdata_i;
  end

  assign sig_valid_o = !empty;
  assign sig_data_o  = empty ? 32'h0 : mem[rd_ptr];
  assign halt_o      = (state_q == ST_DONE);
  assign exit_code_o = exit_code_q;

endmodule

// File: tb/tb_sig_dump_device.sv
// Self-checking bench for sig_dump_device: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_sig_dump_device;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dev_req_i, dev_we_i;
  logic [31:0] dev_addr_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_wdata_i;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dev_err_o;
  logic        sig_valid_o;
  logic        sig_ready_i;
  logic [31:0] sig_data_o;
  logic        halt_o;
  logic [7:0]  exit_code_o;

  sig_dump_device #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dev_req_i    (dev_req_i),
    .dev_we_i     (dev_we_i),
    .dev_addr_i   (dev_addr_i),
    .dev_be_i     (dev_be_i),
    .dev_wdata_i  (dev_wdata_i),
    .dev_rvalid_o (dev_rvalid_o),
    .dev_rdata_o  (dev_rdata_o),
    .dev_err_o    (dev_err_o),
    .sig_valid_o  (sig_valid_o),
    .sig_ready_i  (sig_ready_i),
    .sig_data_o   (sig_data_o),
    .halt_o       (halt_o),
    .exit_code_o  (exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, state as RUN=0 / DRAIN=1 / DONE=2.
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_st;
  logic [7:0]  m_exit;
  bit          e_rvalid;
  logic [31:0] e_rdata;
  bit          e_err;

  logic        last_rvalid;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_st     = 0;
    m_exit   = 8'h00;
    e_rvalid = 1'b0;
    e_rdata  = '0;
    e_err    = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic cyc(input bit rst, input bit req, input bit we, input logic [7:0] off,
                     input logic [3:0] be, input logic [31:0] wd, input bit rdy);
    logic [31:0] addr;
    int          n;
    bit          pop, do_push, do_halt;
    bit          n_err;
    logic [31:0] n_rdata;

    addr      = $urandom;
    addr[9:2] = off;
    rst_i       = rst;
    dev_req_i   = req;
    dev_we_i    = we;
    dev_addr_i  = addr;
    dev_be_i    = be;
    dev_wdata_i = wd;
    sig_ready_i = rdy;

    @(negedge clk_i);
    last_rvalid = dev_rvalid_o;
    last_rdata  = dev_rdata_o;
    last_err    = dev_err_o;
    check("rvalid", {31'h0, dev_rvalid_o}, {31'h0, e_rvalid});
    if (e_rvalid) begin
      check("rdata", dev_rdata_o, e_rdata);
      check("err", {31'h0, dev_err_o}, {31'h0, e_err});
    end
    n = mq.size();
    check("sig_valid", {31'h0, sig_valid_o}, (n != 0) ? 32'd1 : 32'd0);
    check("sig_data", sig_data_o, (n != 0) ? mq[0] : 32'h0);
    check("halt", {31'h0, halt_o}, (m_st == 2) ? 32'd1 : 32'd0);
    check("exit_code", {24'h0, exit_code_o}, {24'h0, m_exit});

    pop     = (n != 0) && rdy;
    do_push = 1'b0;
    do_halt = 1'b0;
    n_err   = 1'b0;
    n_rdata = '0;
    if (req && we) begin
      if (be != 4'hF) n_err = 1'b1;
      else begin
        case (off)
          8'h00: begin
            if (m_st == 0 && (n < DEPTH || pop)) do_push = 1'b1;
            else begin
              n_err = 1'b1;
              if (m_st == 0) m_ovf = 1'b1;
            end
          end
          8'h02: if (m_st == 0) do_halt = 1'b1; else n_err = 1'b1;
          8'h03: m_ovf = 1'b0;
          default: n_err = 1'b1;
        endcase
      end
    end else if (req) begin
      case (off)
        8'h00, 8'h03: n_rdata = '0;
        8'h01: n_rdata = n | ((n == 0) << 16) | ((n == DEPTH) << 17)
                         | (int'(m_ovf) << 18) | ((m_st != 0) << 19);
        8'h02: n_rdata = {24'h0, m_exit};
        default: n_err = 1'b1;
      endcase
    end
    if (m_st == 1 && n == 0) m_st = 2;
    if (do_halt) begin
      m_st   = 1;
      m_exit = wd[7:0];
    end
    if (pop) void'(mq.pop_front());
    if (do_push) mq.push_back(wd);
    e_rvalid = req;
    e_rdata  = n_rdata;
    e_err    = n_err;
    if (rst) model_reset();

    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 8'h00, 4'hF, 32'h0, rdy);
  endtask

  initial begin
    rst_i       = 1'b1;
    dev_req_i   = 1'b0;
    dev_we_i    = 1'b0;
    dev_addr_i  = '0;
    dev_be_i    = 4'h0;
    dev_wdata_i = '0;
    sig_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_rvalid", {31'h0, dev_rvalid_o}, 32'd0);
    check("rst_rdata", dev_rdata_o, 32'd0);
    check("rst_err", {31'h0, dev_err_o}, 32'd0);
    check("rst_sig_valid", {31'h0, sig_valid_o}, 32'd0);
    check("rst_sig_data", sig_data_o, 32'd0);
    check("rst_halt", {31'h0, halt_o}, 32'd0);
    check("rst_exit", {24'h0, exit_code_o}, 32'd0);
    @(posedge clk_i);
    #1;

    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    idle(0);
    check("status_after_reset", last_rdata, 32'h0001_0000);
    check("status_after_reset_err", {31'h0, last_err}, 32'd0);

    // Two pushes held, then popped in order
    cyc(0, 1, 1, 8'h00, 4'hF, 32'hDEAD_BEEF, 0);
    cyc(0, 1, 1, 8'h00, 4'hF, 32'h1234_5678, 0);
    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    idle(0);
    check("status_count2", last_rdata, 32'h0000_0002);
    check("head_first", sig_data_o, 32'hDEAD_BEEF);
    idle(1);
    idle(1);
    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    idle(0);
    check("status_count0", last_rdata, 32'h0001_0000);

    // Overflow on the 17th push, then clear
    for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 1, 8'h00, 4'hF, $urandom, 0);
    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    check("push17_err", {31'h0, last_err}, 32'd1);
    idle(0);
    check("status_full_ovf", last_rdata, 32'h0006_0010);
    cyc(0, 1, 1, 8'h03, 4'hF, 32'h0, 0);
    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    idle(0);
    check("status_full", last_rdata, 32'h0002_0010);

    // Push while full with a same-cycle pop
    cyc(0, 1, 1, 8'h00, 4'hF, 32'hCAFE_0001, 1);
    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    check("full_push_pop_err", {31'h0, last_err}, 32'd0);
    idle(0);
    check("status_full_no_ovf", last_rdata, 32'h0002_0010);
    for (int i = 0; i < DEPTH + 2; i++) idle(1);

    // Halt with three queued words
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'h00, 4'hF, 32'hA000_0000 + i, 0);
    cyc(0, 1, 1, 8'h02, 4'hF, 32'h0000_03A5, 0);
    for (int i = 0; i < 4; i++) idle(0);
    cyc(0, 1, 1, 8'h00, 4'hF, 32'hBAD0_BAD0, 0);
    idle(0);
    check("drain_push_err", {31'h0, last_err}, 32'd1);
    for (int i = 0; i < 6; i++) idle(1);
    check("halt_done", {31'h0, halt_o}, 32'd1);
    check("exit_a5", {24'h0, exit_code_o}, 32'h0000_00A5);

    // Bad byte enables and unmapped offset
    cyc(1, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    cyc(0, 1, 1, 8'h00, 4'h3, 32'h5555_5555, 0);
    cyc(0, 1, 0, 8'h04, 4'hF, 32'h0, 0);
    check("be3_err", {31'h0, last_err}, 32'd1);
    cyc(0, 1, 0, 8'h01, 4'hF, 32'h0, 0);
    check("off10_err", {31'h0, last_err}, 32'd1);
    check("off10_rdata", last_rdata, 32'h0);
    idle(0);
    check("status_unchanged", last_rdata, 32'h0001_0000);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit rdy;
      logic [3:0] be;
      r   = $urandom_range(0, 999);
      rdy = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      be  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      if (r < 5)        cyc(1, $urandom_range(0, 1), 0, 8'h01, 4'hF, 32'h0, rdy);
      else if (r < 550) cyc(0, 1, 1, 8'h00, be, $urandom, rdy);
      else if (r < 700) cyc(0, 1, 0, 8'h01, be, 32'h0, rdy);
      else if (r < 760) cyc(0, 1, 0, 8'($urandom_range(0, 5)), be, 32'h0, rdy);
      else if (r < 772) cyc(0, 1, 1, 8'h02, be, $urandom, rdy);
      else if (r < 800) cyc(0, 1, 1, 8'h03, be, 32'h0, rdy);
      else if (r < 830) cyc(0, 1, 1, 8'($urandom_range(1, 6)), be, $urandom, rdy);
      else              idle(rdy);
    end
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
